// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg : shared types and constants for the APB requester
// Revision: 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Register map of the sin peripheral this requester usually talks to
  localparam logic [31:0] CTRL_ADDR = 32'h0000_0000;
  localparam logic [31:0] OUT_ADDR  = 32'h0000_0004;

  function automatic logic state_selects(input apb_state_t s);
    return (s == SETUP) || (s == ACCESS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
// ============================================================================
// apb_timeout_cnt : counts ACCESS wait cycles, flags the last allowed one
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // Count holds k-1 during the k-th ACCESS cycle, so this marks the final one
  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// apb_master : single-outstanding command interface to APB SETUP/ACCESS
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_t state;
  apb_state_t next_state;
  logic       timeout_hit;
  logic       access_done;

`ifdef APB_TIMEOUT_EN
  logic err_q;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (next_state == SETUP),
    .enable ((state == ACCESS) && !PREADY),
    .expired(timeout_hit)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      err_q <= 1'b0;
    end else if (access_done) begin
      err_q <= !PREADY;
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  assign access_done = (state == ACCESS) && (PREADY || timeout_hit);
  assign cmd_ready   = (state == IDLE) && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid)   next_state = SETUP;
      SETUP:                    next_state = ACCESS;
      ACCESS:  if (access_done) next_state = RESP;
      RESP:                     next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // Control outputs are registered from next_state so they line up with state
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      PSEL      <= state_selects(next_state);
      PENABLE   <= (next_state == ACCESS);
      rsp_valid <= (next_state == RESP);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_rdata <= '0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
      // Writes and timed-out transfers report zero data
      if (access_done) begin
        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// tb_apb_master : scoreboard bench with a wait-state APB completer model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_master;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  // ---------------- completer model ----------------
  logic [31:0] regs [0:7];
  bit          init_done   = 1'b0;
  int          wait_cfg    = 0;
  bit          hang        = 1'b0;
  bit          force_ready = 1'b0;
  int          acc_cnt     = 0;
  logic        slave_ready;

  assign slave_ready = PSEL && PENABLE && !hang && (acc_cnt >= wait_cfg);
  assign PREADY      = slave_ready | (force_ready & ~(PSEL & PENABLE));
  assign PRDATA      = PSEL ? regs[PADDR[4:2]] : 32'hDEAD_BEEF;

  always @(posedge PCLK) begin
    if (!init_done) begin
      for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
      regs[OUT_ADDR[4:2]] <= 32'h3F35_04F3;
      init_done <= 1'b1;
    end else if (PSEL && PENABLE && PREADY && PWRITE) begin
      regs[PADDR[4:2]] <= PWDATA;
    end
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          hs;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge PCLK) begin
    if (!PRESET && rsp_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_rsp_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", rsp_err, mon_e.err);
        check("rsp_latency", 64'(cyc - mon_e.hs), 64'(mon_e.lat));
        check("rsp_psel_penable_low", {PSEL, PENABLE}, 2'b00);
      end
    end
    if (!PRESET && PSEL) begin
      check("apb_hold_stable", {PWRITE, PADDR, PWDATA}, {cur_write, cur_addr, cur_wdata});
    end
    if (!PRESET && PENABLE && !PSEL) check("penable_without_psel", 64'd1, 64'd0);
  end

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input bit exp_err, input int lat,
                       input bit push, input bit hold, output int hs);
    int n;
    exp_t e;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) begin
      check("handshake_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      hs = -1;
      return;
    end
    hs        = cyc;
    cur_write = wr;
    cur_addr  = addr;
    cur_wdata = wdata;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = lat;
      e.hs    = hs;
      sbq.push_back(e);
    end
    @(posedge PCLK);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (sbq.size() != 0) begin
      check("rsp_never_arrived", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, h2, n;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cur_write = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;

    // Reset state
    repeat (3) @(negedge PCLK);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE},
          6'b000000);
    check("reset_bus", {PADDR, PWDATA, rsp_rdata}, 96'h0);
    PRESET = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1'b1);

    // 1: write 0x0 <= 0x3, zero waits, phase-by-phase
    wait_cfg = 0;
    issue(1'b1, CTRL_ADDR, 32'h3, 32'h0, 1'b0, 3, 1'b1, 1'b0, h0);
    @(negedge PCLK);
    check("t1_setup", {PSEL, PENABLE, cmd_ready}, 3'b100);
    @(negedge PCLK);
    check("t1_access", {PSEL, PENABLE, PWRITE}, 3'b111);
    check("t1_addr_data", {PADDR, PWDATA}, {32'h0, 32'h3});
    wait_idle();

    // 2: read 0x4, one wait state
    wait_cfg = 1;
    issue(1'b0, OUT_ADDR, 32'h0, 32'h3F35_04F3, 1'b0, 4, 1'b1, 1'b0, h0);
    wait_idle();
    repeat (3) @(negedge PCLK);
    check("t2_rdata_hold", {rsp_rdata, rsp_err}, {32'h3F35_04F3, 1'b0});

    // 3: cmd_valid held across three commands
    wait_cfg = 0;
    issue(1'b1, 32'h8, 32'hA5A5_0001, 32'h0, 1'b0, 3, 1'b1, 1'b1, h0);
    issue(1'b1, 32'hC, 32'h1234_5678, 32'h0, 1'b0, 3, 1'b1, 1'b1, h1);
    issue(1'b0, 32'h8, 32'h0, 32'hA5A5_0001, 1'b0, 3, 1'b1, 1'b0, h2);
    check("t3_spacing_1", 64'(h1 - h0), 64'd4);
    check("t3_spacing_2", 64'(h2 - h1), 64'd4);
    wait_idle();

    // 4: reset during ACCESS of a read drops it
    wait_cfg = 5;
    issue(1'b0, OUT_ADDR, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0, h0);
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check("t4_reached_access", PENABLE, 1'b1);
    PRESET    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h10;
    #1;
    check("t4_ready_low_in_reset", cmd_ready, 1'b0);
    @(negedge PCLK);
    check("t4_ctrl_zero", {rsp_valid, rsp_err, PSEL, PENABLE, PWRITE}, 5'b00000);
    check("t4_bus_zero", {PADDR, PWDATA, rsp_rdata}, 96'h0);
    PRESET    = 1'b0;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("t4_no_accept_in_reset", {PSEL, rsp_valid}, 2'b00);
    wait_cfg = 0;
    issue(1'b0, CTRL_ADDR, 32'h0, 32'h3, 1'b0, 3, 1'b1, 1'b0, h0);
    wait_idle();

`ifdef APB_TIMEOUT_EN
    // 5: completer never answers
    hang = 1'b1;
    issue(1'b1, 32'h8, 32'h77, 32'h0, 1'b1, 2 + TO, 1'b1, 1'b0, h0);
    wait_idle();
    hang = 1'b0;
    check("t5_psel_dropped", {PSEL, PENABLE}, 2'b00);
`endif

    // 6: PREADY forced high outside ACCESS is ignored
    force_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("t6_idle_quiet", {PSEL, rsp_valid}, 2'b00);
    end
    wait_cfg = 1;
    issue(1'b1, 32'h10, 32'h55, 32'h0, 1'b0, 4, 1'b1, 1'b0, h0);
    wait_idle();
    force_ready = 1'b0;
    wait_cfg    = 0;
    issue(1'b0, 32'h10, 32'h0, 32'h55, 1'b0, 3, 1'b1, 1'b0, h0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
